// File: rtl/ariane_pkg.sv
// Minimal stand-in for the core package; provides the scoreboard transaction-id width.
package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;
endpackage

// File: rtl/serdiv_req_queue_if.sv
// Issue-side request and divider-side handshake bundle for serdiv_req_queue.
// slave = the queue itself; master = the environment driving requests / modelling the divider.
interface serdiv_req_queue_if #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
);
  logic                     req_vld_i;
  logic                     req_rdy_o;
  logic [TRANS_ID_BITS-1:0] req_id_i;
  logic [WIDTH-1:0]         req_op_a_i;
  logic [WIDTH-1:0]         req_op_b_i;
  logic [1:0]               req_opcode_i;
  logic                     req_op_a_label_i;
  logic                     req_op_b_label_i;

  logic                     div_vld_o;
  logic                     div_rdy_i;
  logic [TRANS_ID_BITS-1:0] div_id_o;
  logic [WIDTH-1:0]         div_op_a_o;
  logic [WIDTH-1:0]         div_op_b_o;
  logic [1:0]               div_opcode_o;
  logic                     div_op_a_label_o;
  logic                     div_op_b_label_o;

  modport slave (
    input  req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
           req_op_a_label_i, req_op_b_label_i, div_rdy_i,
    output req_rdy_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
           div_op_a_label_o, div_op_b_label_o
  );

  modport master (
    output req_vld_i, req_id_i, req_op_a_i, req_op_b_i, req_opcode_i,
           req_op_a_label_i, req_op_b_label_i, div_rdy_i,
    input  req_rdy_o, div_vld_o, div_id_o, div_op_a_o, div_op_b_o, div_opcode_o,
           div_op_a_label_o, div_op_b_label_o
  );
endinterface

// File: rtl/serdiv_req_queue.sv
// In-order request FIFO in front of the serial divider; push->div_vld_o latency 1 cycle, 0 with
// SERDIV_REQ_QUEUE_BYPASS_EN. Backpressure: req_rdy_o low when full/flushing; pops gated by registered divider ready.
module serdiv_req_queue #(
  parameter int unsigned WIDTH         = 64,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = ariane_pkg::TRANS_ID_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  serdiv_req_queue_if.slave          q,
  output logic [$clog2(DEPTH+1)-1:0] occ_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] id;
    logic [WIDTH-1:0]         op_a;
    logic [WIDTH-1:0]         op_b;
    logic [1:0]               opcode;
    logic                     a_label;
    logic                     b_label;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             req_ent;
  entry_t             out_ent;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               div_rdy_q, div_rdy_d;
  logic               empty, full, req_rdy, queue_vld, bypass, push, pop;

  assign req_ent = '{id:      q.req_id_i,
                     op_a:    q.req_op_a_i,
                     op_b:    q.req_op_b_i,
                     opcode:  q.req_opcode_i,
                     a_label: q.req_op_a_label_i,
                     b_label: q.req_op_b_label_i};

  assign empty = (occ_q == '0);
  assign full  = (occ_q == OCC_W'(DEPTH));

  // rst_ni term keeps ready low while reset is held, not just after the first edge
  assign req_rdy   = rst_ni && !full && !flush_i;
  // div_rdy_q covers the divider's one-cycle gap between in_rdy_o rising and it sampling a valid
  assign queue_vld = !empty && div_rdy_q && q.div_rdy_i && !flush_i;

`ifdef SERDIV_REQ_QUEUE_BYPASS_EN
  assign bypass = empty && div_rdy_q && q.div_rdy_i && q.req_vld_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign push    = q.req_vld_i && req_rdy && !bypass;
  assign pop     = queue_vld;
  assign out_ent = bypass ? req_ent : mem_q[rd_ptr_q];

  assign q.req_rdy_o        = req_rdy;
  assign q.div_vld_o        = queue_vld || bypass;
  assign q.div_id_o         = out_ent.id;
  assign q.div_op_a_o       = out_ent.op_a;
  assign q.div_op_b_o       = out_ent.op_b;
  assign q.div_opcode_o     = out_ent.opcode;
  assign q.div_op_a_label_o = out_ent.a_label;
  assign q.div_op_b_label_o = out_ent.b_label;
  assign occ_o              = occ_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    div_rdy_d = q.div_rdy_i;
    mem_d     = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = req_ent;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      div_rdy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      div_rdy_q <= div_rdy_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_serdiv_req_queue.sv
// Directed bench for serdiv_req_queue (WIDTH=64, DEPTH=2); checks sampled on the falling edge.
module tb_serdiv_req_queue;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TIDW  = ariane_pkg::TRANS_ID_BITS;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic [1:0] occ_o;
  int         checks = 0;
  int         errors = 0;

  serdiv_req_queue_if #(.WIDTH(WIDTH), .TRANS_ID_BITS(TIDW)) qif ();

  serdiv_req_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .q       (qif.slave),
    .occ_o   (occ_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the rising edge; sample on the falling edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic req(input logic v, input logic [TIDW-1:0] id, input logic [63:0] a,
                     input logic [63:0] b, input logic [1:0] op, input logic la, input logic lb);
    qif.req_vld_i        = v;
    qif.req_id_i         = id;
    qif.req_op_a_i       = a;
    qif.req_op_b_i       = b;
    qif.req_opcode_i     = op;
    qif.req_op_a_label_i = la;
    qif.req_op_b_label_i = lb;
  endtask

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    qif.div_rdy_i = 1'b1;
    req(1'b1, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);

    // Reset state, with request valid and divider ready both asserted
    smp();
    chk("rst_occ", 64'(occ_o), 64'd0);
    chk("rst_req_rdy", 64'(qif.req_rdy_o), 64'd0);
    chk("rst_div_vld", 64'(qif.div_vld_o), 64'd0);

    // Release: ready in the very first cycle; idle cycle lets div_rdy_q settle
    cyc(); rst_ni = 1'b1; req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    smp(); chk("first_req_rdy", 64'(qif.req_rdy_o), 64'd1);

    // Single request with divider continuously ready
    cyc(); req(1'b1, 3'd3, 64'd100, 64'd7, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t1_push_rdy", 64'(qif.req_rdy_o), 64'd1);
`ifdef SERDIV_REQ_QUEUE_BYPASS_EN
    chk("t1_byp_vld", 64'(qif.div_vld_o), 64'd1);
    chk("t1_byp_id", 64'(qif.div_id_o), 64'd3);
    chk("t1_byp_a", qif.div_op_a_o, 64'd100);
    chk("t1_byp_b", qif.div_op_b_o, 64'd7);
    chk("t1_byp_occ", 64'(occ_o), 64'd0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t1_after_vld", 64'(qif.div_vld_o), 64'd0);
    chk("t1_after_occ", 64'(occ_o), 64'd0);
`else
    chk("t1_push_vld", 64'(qif.div_vld_o), 64'd0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t1_vld", 64'(qif.div_vld_o), 64'd1);
    chk("t1_id", 64'(qif.div_id_o), 64'd3);
    chk("t1_a", qif.div_op_a_o, 64'd100);
    chk("t1_b", qif.div_op_b_o, 64'd7);
    chk("t1_opcode", 64'(qif.div_opcode_o), 64'd0);
    chk("t1_occ1", 64'(occ_o), 64'd1);
`endif
    cyc();
    smp();
    chk("t1_drained_occ", 64'(occ_o), 64'd0);
    chk("t1_drained_vld", 64'(qif.div_vld_o), 64'd0);

    // Two requests while the divider is busy, then release in order
    cyc(); qif.div_rdy_i = 1'b0; req(1'b1, 3'd1, 64'd11, 64'd1, 2'd1, 1'b0, 1'b0);
    cyc(); req(1'b1, 3'd2, 64'd22, 64'd2, 2'd1, 1'b0, 1'b0);
    cyc(); req(1'b1, 3'd7, 64'd99, 64'd9, 2'd1, 1'b0, 1'b0);
    smp();
    chk("t2_occ_full", 64'(occ_o), 64'd2);
    chk("t2_rdy_full", 64'(qif.req_rdy_o), 64'd0);
    chk("t2_vld_busy", 64'(qif.div_vld_o), 64'd0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    smp();
    chk("t2_no_overfill", 64'(occ_o), 64'd2);
    chk("t2_vld_delay", 64'(qif.div_vld_o), 64'd0);
    cyc();
    smp();
    chk("t2_vld_a", 64'(qif.div_vld_o), 64'd1);
    chk("t2_id_a", 64'(qif.div_id_o), 64'd1);
    cyc();
    smp();
    chk("t2_vld_b", 64'(qif.div_vld_o), 64'd1);
    chk("t2_id_b", 64'(qif.div_id_o), 64'd2);
    chk("t2_occ_b", 64'(occ_o), 64'd1);
    cyc();
    smp();
    chk("t2_empty_occ", 64'(occ_o), 64'd0);
    chk("t2_empty_vld", 64'(qif.div_vld_o), 64'd0);

    // Full queue: a pop frees a slot but a same-cycle push is refused; then push+pop at occ 1, across the wrap
    cyc(); qif.div_rdy_i = 1'b0; req(1'b1, 3'd2, 64'd10, 64'd1, 2'd2, 1'b0, 1'b0);
    cyc(); req(1'b1, 3'd3, 64'd11, 64'd1, 2'd2, 1'b0, 1'b0);
    cyc(); req(1'b1, 3'd4, 64'd12, 64'd1, 2'd2, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    smp();
    chk("t3_full_rdy", 64'(qif.req_rdy_o), 64'd0);
    chk("t3_full_vld", 64'(qif.div_vld_o), 64'd0);
    cyc();
    smp();
    chk("t3_pop_vld", 64'(qif.div_vld_o), 64'd1);
    chk("t3_pop_a", qif.div_op_a_o, 64'd10);
    chk("t3_pop_rdy", 64'(qif.req_rdy_o), 64'd0);
    cyc(); req(1'b1, 3'd5, 64'd13, 64'd1, 2'd2, 1'b0, 1'b0);
    smp();
    chk("t3_occ_after_pop", 64'(occ_o), 64'd1);
    chk("t3_head_b", qif.div_op_a_o, 64'd11);
    chk("t3_pp_rdy", 64'(qif.req_rdy_o), 64'd1);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t3_pp_occ", 64'(occ_o), 64'd1);
    chk("t3_tail_a", qif.div_op_a_o, 64'd13);
    chk("t3_tail_id", 64'(qif.div_id_o), 64'd5);
    cyc();
    smp();
    chk("t3_empty_occ", 64'(occ_o), 64'd0);

    // Flush with two entries queued and the divider ready: no pop, flush-cycle request dropped
    cyc(); qif.div_rdy_i = 1'b0; req(1'b1, 3'd4, 64'd20, 64'd1, 2'd0, 1'b0, 1'b0);
    cyc(); req(1'b1, 3'd5, 64'd21, 64'd1, 2'd0, 1'b0, 1'b0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    smp();
    chk("t4_pre_occ", 64'(occ_o), 64'd2);
    cyc(); flush_i = 1'b1; req(1'b1, 3'd6, 64'd22, 64'd1, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t4_flush_vld", 64'(qif.div_vld_o), 64'd0);
    chk("t4_flush_rdy", 64'(qif.req_rdy_o), 64'd0);
    cyc(); flush_i = 1'b0; qif.div_rdy_i = 1'b0; req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0);
    smp();
    chk("t4_occ", 64'(occ_o), 64'd0);
    chk("t4_vld", 64'(qif.div_vld_o), 64'd0);
    cyc(); req(1'b1, 3'd7, 64'd23, 64'd1, 2'd0, 1'b0, 1'b0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    smp();
    chk("t4_after_occ", 64'(occ_o), 64'd1);
    chk("t4_after_head", qif.div_op_a_o, 64'd23);
    cyc();
    smp();
    chk("t4_drain_id", 64'(qif.div_id_o), 64'd7);
    chk("t4_drain_vld", 64'(qif.div_vld_o), 64'd1);
    cyc();
    smp();
    chk("t4_drained", 64'(occ_o), 64'd0);

    // Labels and opcode travel with their entries
    cyc(); qif.div_rdy_i = 1'b0; req(1'b1, 3'd4, 64'd40, 64'd4, 2'd3, 1'b1, 1'b0);
    cyc(); req(1'b1, 3'd5, 64'd50, 64'd5, 2'd2, 1'b0, 1'b1);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    cyc();
    smp();
    chk("t5_vld_a", 64'(qif.div_vld_o), 64'd1);
    chk("t5_la_a", 64'(qif.div_op_a_label_o), 64'd1);
    chk("t5_lb_a", 64'(qif.div_op_b_label_o), 64'd0);
    chk("t5_op_a", 64'(qif.div_opcode_o), 64'd3);
    cyc();
    smp();
    chk("t5_la_b", 64'(qif.div_op_a_label_o), 64'd0);
    chk("t5_lb_b", 64'(qif.div_op_b_label_o), 64'd1);
    chk("t5_op_b", 64'(qif.div_opcode_o), 64'd2);
    chk("t5_id_b", 64'(qif.div_id_o), 64'd5);
    cyc();

    // Mid-operation reset with one entry ready to pop
    cyc(); qif.div_rdy_i = 1'b0; req(1'b1, 3'd6, 64'd60, 64'd6, 2'd0, 1'b0, 1'b0);
    cyc(); req(1'b0, 3'd0, 64'd0, 64'd0, 2'd0, 1'b0, 1'b0); qif.div_rdy_i = 1'b1;
    cyc(); rst_ni = 1'b0;
    smp();
    chk("t6_rst_vld", 64'(qif.div_vld_o), 64'd0);
    chk("t6_rst_occ", 64'(occ_o), 64'd0);
    cyc(); rst_ni = 1'b1;
    smp();
    chk("t6_rel_occ", 64'(occ_o), 64'd0);
    cyc();
    smp();
    chk("t6_rel_vld", 64'(qif.div_vld_o), 64'd0);
    chk("t6_rel_occ2", 64'(occ_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
